// File: rtl/roulette_pkg.sv
// Shared constants and state encoding for the roulette bet front end.
package roulette_pkg;
  localparam int MAX_BETS = 12;
  localparam int OPC_W    = 6;
  localparam int COL_W    = 2;
  localparam int BET_W    = COL_W + OPC_W;
  localparam int CNT_W    = 4;

  localparam logic [OPC_W-1:0] OPC_NONE    = 6'h3F;
  localparam logic [OPC_W-1:0] OPC_SPIN    = 6'h3E;
  localparam logic [2:0]       COLOUR_NONE = 3'b000;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_RELEASE = 2'd1,
    ST_SPIN    = 2'd2
  } state_t;
endpackage

// File: rtl/bet_slot_file.sv
// Register array holding the packed bets, flattened onto one bus.
module bet_slot_file
  import roulette_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_we,
  input  logic [CNT_W-1:0]          i_idx,
  input  logic [BET_W-1:0]          i_wdata,
  input  logic                      i_clr,
  output logic [MAX_BETS*BET_W-1:0] o_bets
);
  logic [BET_W-1:0] r_slot [MAX_BETS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < MAX_BETS; k++)
        r_slot[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < MAX_BETS; k++)
        r_slot[k] <= '0;
    end else if (i_we && i_idx < CNT_W'(MAX_BETS)) begin
      r_slot[i_idx] <= i_wdata;
    end
  end

  always_comb begin
    o_bets = '0;
    for (int k = 0; k < MAX_BETS; k++)
      o_bets[k*BET_W +: BET_W] = r_slot[k];
  end
endmodule

// File: rtl/bet_capture_unit.sv
// Keyboard bet capture: de-duplicates key strobes into a bet table
// and handles the spin request / spin done handshake.
module bet_capture_unit
  import roulette_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      read_data,
  input  logic [OPC_W-1:0]          bet_opcode,
  input  logic [2:0]                colour_in,
  input  logic                      spin_done,
  output logic [MAX_BETS*BET_W-1:0] bets,
  output logic [CNT_W-1:0]          bet_count,
  output logic                      spin_check,
  output logic                      table_full,
  output logic                      reject_pulse
);
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic             r_spin;
  logic             r_rej;
  logic             w_we;
  logic             w_clr;
  logic             w_set_spin;
  logic             w_rej;
  logic             w_full;
  logic             w_none;
  logic             w_spin_key;
  logic [BET_W-1:0] w_wdata;

  assign w_full     = (r_count == CNT_W'(MAX_BETS));
  assign w_none     = (bet_opcode == OPC_NONE);
  assign w_spin_key = (bet_opcode == OPC_SPIN);
  assign w_wdata    = {colour_in[COL_W-1:0], bet_opcode};

  always_comb begin
    w_next     = r_state;
    w_we       = 1'b0;
    w_clr      = 1'b0;
    w_set_spin = 1'b0;
    w_rej      = 1'b0;
    unique case (r_state)
      ST_COLLECT: begin
        if (read_data && !w_none) begin
          if (w_spin_key) begin
            if (r_count != '0) begin
              w_set_spin = 1'b1;
              w_next     = ST_SPIN;
            end else begin
              w_rej = 1'b1;
            end
          end else if (colour_in != COLOUR_NONE && !w_full) begin
            w_we   = 1'b1;
            w_next = ST_RELEASE;
          end else begin
            w_rej = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        if (read_data) begin
          if (w_none) w_next = ST_COLLECT;
          else        w_rej  = 1'b1;
        end
      end
      ST_SPIN: begin
        // spin_done takes priority; a coincident strobe is dropped
        if (spin_done) begin
          w_clr  = 1'b1;
          w_next = ST_COLLECT;
        end else if (read_data && !w_none) begin
          w_rej = 1'b1;
        end
      end
      default: w_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_COLLECT;
      r_count <= '0;
      r_spin  <= 1'b0;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rej   <= w_rej;
      if (w_clr)      r_count <= '0;
      else if (w_we)  r_count <= r_count + CNT_W'(1);
      if (w_clr)           r_spin <= 1'b0;
      else if (w_set_spin) r_spin <= 1'b1;
    end
  end

  bet_slot_file u_slots (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_we    (w_we),
    .i_idx   (r_count),
    .i_wdata (w_wdata),
    .i_clr   (w_clr),
    .o_bets  (bets)
  );

  assign bet_count    = r_count;
  assign spin_check   = r_spin;
  assign table_full   = w_full;
  assign reject_pulse = r_rej;
endmodule

// File: tb/tb_bet_capture_unit.sv
// Randomised + directed bench for bet_capture_unit against a
// queue-based reference of the bet table.
module tb_bet_capture_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        read_data = 1'b0;
  logic [5:0]  bet_opcode = 6'h3F;
  logic [2:0]  colour_in = 3'b000;
  logic        spin_done = 1'b0;
  logic [95:0] bets;
  logic [3:0]  bet_count;
  logic        spin_check;
  logic        table_full;
  logic        reject_pulse;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_q[$];
  bit         m_rel;
  bit         m_spn;
  bit         m_rej;

  always #5 clock = ~clock;

  bet_capture_unit dut (
    .clock        (clock),
    .reset        (reset),
    .read_data    (read_data),
    .bet_opcode   (bet_opcode),
    .colour_in    (colour_in),
    .spin_done    (spin_done),
    .bets         (bets),
    .bet_count    (bet_count),
    .spin_check   (spin_check),
    .table_full   (table_full),
    .reject_pulse (reject_pulse)
  );

  task automatic chk(string tag, logic [95:0] got, logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [95:0] m_bus();
    logic [95:0] b;
    b = '0;
    foreach (m_q[k]) b[k*8 +: 8] = m_q[k];
    return b;
  endfunction

  task automatic chk_all(string tag);
    chk({tag, ".bets"}, bets, m_bus());
    chk({tag, ".cnt"}, 96'(bet_count), 96'(m_q.size()));
    chk({tag, ".spin"}, 96'(spin_check), 96'(m_spn));
    chk({tag, ".full"}, 96'(table_full), 96'(m_q.size() == 12));
    chk({tag, ".rej"}, 96'(reject_pulse), 96'(m_rej));
  endtask

  task automatic model(bit rd, logic [5:0] op, logic [2:0] col, bit dn);
    m_rej = 0;
    if (m_spn) begin
      if (dn) begin
        m_q.delete();
        m_spn = 0;
      end else if (rd && op != 6'h3F) m_rej = 1;
    end else if (m_rel) begin
      if (rd) begin
        if (op == 6'h3F) m_rel = 0;
        else m_rej = 1;
      end
    end else if (rd && op != 6'h3F) begin
      if (op == 6'h3E) begin
        if (m_q.size() > 0) m_spn = 1;
        else m_rej = 1;
      end else if (col != 0 && m_q.size() < 12) begin
        m_q.push_back({col[1:0], op});
        m_rel = 1;
      end else m_rej = 1;
    end
  endtask

  task automatic step(bit rd, logic [5:0] op, logic [2:0] col, bit dn,
                      string tag);
    read_data  = rd;
    bet_opcode = op;
    colour_in  = col;
    spin_done  = dn;
    @(posedge clock);
    #1;
    model(rd, op, col, dn);
    chk_all(tag);
    read_data = 0;
    spin_done = 0;
  endtask

  task automatic do_reset(string tag);
    reset = 0;
    #1;
    m_q.delete();
    m_rel = 0;
    m_spn = 0;
    m_rej = 0;
    chk_all(tag);
    #2 reset = 1;
  endtask

  task automatic bet_pair(logic [5:0] op, logic [2:0] col, string tag);
    step(1, op, col, 0, tag);
    step(1, 6'h3F, 3'b000, 0, tag);
  endtask

  initial begin
    #12;
    do_reset("rst0");
    @(posedge clock);
    #1;

    // T4
    step(1, 6'h07, 3'b000, 0, "t4_nocol");
    chk("t4_rej", 96'(reject_pulse), 96'd1);
    step(1, 6'h3E, 3'b001, 0, "t4_spin_empty");
    chk("t4_spin0", 96'(spin_check), 96'd0);

    // T2
    step(1, 6'h05, 3'b010, 0, "t2_bet");
    step(1, 6'h3F, 3'b000, 0, "t2_rel");
    chk("t2_slot0", 96'(bets[7:0]), 96'h85);
    chk("t2_cnt", 96'(bet_count), 96'd1);

    // T3
    step(1, 6'h05, 3'b011, 0, "t3_a");
    step(1, 6'h05, 3'b011, 0, "t3_b");
    chk("t3_rej", 96'(reject_pulse), 96'd1);
    chk("t3_cnt", 96'(bet_count), 96'd2);
    step(1, 6'h3F, 3'b000, 0, "t3_rel");

    // T1
    repeat (3) bet_pair(6'($urandom_range(0, 61)), 3'b001, "t1_fill");
    chk("t1_cnt5", 96'(bet_count), 96'd5);
    do_reset("t1_rst");

    // T5
    for (int i = 0; i < 13; i++)
      bet_pair(6'(i), 3'($urandom_range(1, 7)), "t5_fill");
    chk("t5_cnt", 96'(bet_count), 96'd12);
    chk("t5_full", 96'(table_full), 96'd1);
    step(1, 6'h20, 3'b010, 0, "t5_over");
    chk("t5_rej", 96'(reject_pulse), 96'd1);
    chk("t5_slot11", 96'(bets[95:88]), 96'(m_q[11]));
    do_reset("t5_rst");

    // T6
    for (int i = 0; i < 3; i++)
      bet_pair(6'(i + 9), 3'b110, "t6_fill");
    step(1, 6'h3E, 3'b000, 0, "t6_spin");
    chk("t6_spin1", 96'(spin_check), 96'd1);
    step(1, 6'h11, 3'b001, 0, "t6_frozen");
    chk("t6_rej", 96'(reject_pulse), 96'd1);
    step(1, 6'h12, 3'b001, 1, "t6_done");
    chk("t6_cnt0", 96'(bet_count), 96'd0);
    chk("t6_norej", 96'(reject_pulse), 96'd0);

    // reset during a pending spin
    bet_pair(6'h01, 3'b001, "rs_fill");
    step(1, 6'h3E, 3'b000, 0, "rs_spin");
    do_reset("rs_rst");

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [5:0] op;
      r = $urandom_range(0, 99);
      if (r < 35)      op = 6'h3F;
      else if (r < 45) op = 6'h3E;
      else             op = 6'($urandom_range(0, 61));
      step($urandom_range(0, 9) < 7, op,
           ($urandom_range(0, 9) < 2) ? 3'b000 : 3'($urandom_range(1, 7)),
           $urandom_range(0, 19) == 0, "rand");
      if (i == 1500) do_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
